// File: rtl/player_mover.sv
// player_mover: player-dot controller for the collision/VGA path.
// Turns synchronized key levels into single-step dot moves, runs the
// IDLE/PLAY/DEAD/WIN round state, counts crossings and respawns after a hit.
// Optional feature macro: PLAYER_AUTOREPEAT_EN (held key repeats its move
// every REPEAT_CYCLES while in PLAY). Undefined: one move per rising edge.
module player_mover #(
  parameter logic [7:0]  X_START        = 8'd80,
  parameter logic [6:0]  Y_START        = 7'd110,
  parameter logic [7:0]  X_STEP         = 8'd2,
  parameter logic [6:0]  Y_STEP         = 7'd20,
  parameter logic [7:0]  X_MAX          = 8'd159,
  parameter logic [24:0] RESPAWN_CYCLES = 25'd25000000,
  parameter logic [23:0] REPEAT_CYCLES  = 24'd5000000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       go,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       hit,
  output logic [7:0] x_dot,
  output logic [6:0] y_dot,
  output logic [7:0] score,
  output logic       win_pulse,
  output logic       dead
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DEAD = 2'd2,
    S_WIN  = 2'd3
  } state_t;

  state_t      r_state;
  logic [7:0]  r_x;
  logic [6:0]  r_y;
  logic [7:0]  r_score;
  logic        r_win;
  logic        r_dead;
  logic [24:0] r_timer;
  logic        r_up_q;
  logic        r_down_q;
  logic        r_left_q;
  logic        r_right_q;

  logic [3:0]  w_press;     // {up, down, left, right} rising edges
  logic [3:0]  w_press_sel; // highest-priority press, one-hot
  logic [3:0]  w_sel;       // move to apply this cycle, one-hot
  logic [7:0]  w_nx;
  logic [6:0]  w_ny;
  logic        w_win;
  logic [7:0]  w_y_dn;
  logic [8:0]  w_x_rt;

  function automatic logic [3:0] pri4(input logic [3:0] v);
    logic [3:0] o;
    o = '0;
    if (v[3])      o[3] = 1'b1;
    else if (v[2]) o[2] = 1'b1;
    else if (v[1]) o[1] = 1'b1;
    else if (v[0]) o[0] = 1'b1;
    return o;
  endfunction

  // Key edge detection and priority select of the single press for this cycle
  always_comb begin
    w_press     = {key_up & ~r_up_q, key_down & ~r_down_q,
                   key_left & ~r_left_q, key_right & ~r_right_q};
    w_press_sel = pri4(w_press);
  end

`ifdef PLAYER_AUTOREPEAT_EN
  logic [3:0]  r_rep_sel;
  logic [23:0] r_rep_cnt;
  logic [3:0]  w_held_sel;
  logic        w_rep_fire;

  // Repeat fires only while the same highest-priority key stays held
  always_comb begin
    w_held_sel = pri4({key_up, key_down, key_left, key_right});
    w_rep_fire = (w_held_sel != 4'd0) && (w_held_sel == r_rep_sel) &&
                 (r_rep_cnt == REPEAT_CYCLES - 24'd1);
    if (w_press_sel != 4'd0) w_sel = w_press_sel;
    else if (w_rep_fire)     w_sel = w_held_sel;
    else                     w_sel = '0;
  end

  // Repeat counter: restarts on a fresh press, a fired repeat, or a key change
  always_ff @(posedge CLK) begin
    if (reset || r_state != S_PLAY) begin
      r_rep_sel <= '0;
      r_rep_cnt <= '0;
    end else begin
      r_rep_sel <= w_held_sel;
      if ((w_press_sel != 4'd0) || (w_held_sel != r_rep_sel) || w_rep_fire)
        r_rep_cnt <= '0;
      else
        r_rep_cnt <= r_rep_cnt + 24'd1;
    end
  end
`else
  logic w_unused_rep;
  assign w_unused_rep = ^REPEAT_CYCLES;

  // Without auto-repeat only a fresh press moves the dot
  always_comb begin
    w_sel = w_press_sel;
  end
`endif

  // Next dot position; sums are widened so edge clamps never see a wrap
  always_comb begin
    w_nx   = r_x;
    w_ny   = r_y;
    w_win  = 1'b0;
    w_y_dn = {1'b0, r_y} + {1'b0, Y_STEP};
    w_x_rt = {1'b0, r_x} + {1'b0, X_STEP};
    if (w_sel[3]) begin
      if (r_y < Y_STEP) w_win = 1'b1;
      else              w_ny  = r_y - Y_STEP;
    end else if (w_sel[2]) begin
      if (w_y_dn <= {1'b0, Y_START}) w_ny = w_y_dn[6:0];
    end else if (w_sel[1]) begin
      w_nx = (r_x < X_STEP) ? 8'd0 : r_x - X_STEP;
    end else if (w_sel[0]) begin
      w_nx = (r_x > X_MAX - X_STEP) ? X_MAX : w_x_rt[7:0];
    end
  end

  // Round state machine with registered outputs and key history
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_x       <= X_START;
      r_y       <= Y_START;
      r_score   <= '0;
      r_win     <= 1'b0;
      r_dead    <= 1'b0;
      r_timer   <= '0;
      r_up_q    <= 1'b0;
      r_down_q  <= 1'b0;
      r_left_q  <= 1'b0;
      r_right_q <= 1'b0;
    end else begin
      r_up_q    <= key_up;
      r_down_q  <= key_down;
      r_left_q  <= key_left;
      r_right_q <= key_right;
      case (r_state)
        S_IDLE: begin
          r_x <= X_START;
          r_y <= Y_START;
          if (go) r_state <= S_PLAY;
        end
        S_PLAY: begin
          if (hit) begin
            r_state <= S_DEAD;
            r_dead  <= 1'b1;
            r_timer <= '0;
          end else if (w_win) begin
            // Crossing outputs are loaded on entry so they show during the WIN cycle
            r_state <= S_WIN;
            r_win   <= 1'b1;
            r_score <= (r_score == 8'hFF) ? r_score : r_score + 8'd1;
            r_x     <= X_START;
            r_y     <= Y_START;
          end else begin
            r_x <= w_nx;
            r_y <= w_ny;
          end
        end
        S_DEAD: begin
          if (r_timer == RESPAWN_CYCLES - 25'd1) begin
            r_state <= S_IDLE;
            r_dead  <= 1'b0;
            r_timer <= '0;
            r_score <= '0;
            r_x     <= X_START;
            r_y     <= Y_START;
          end else begin
            r_timer <= r_timer + 25'd1;
          end
        end
        S_WIN: begin
          r_win   <= 1'b0;
          r_state <= S_PLAY;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign x_dot     = r_x;
  assign y_dot     = r_y;
  assign score     = r_score;
  assign win_pulse = r_win;
  assign dead      = r_dead;

endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover (default build, short respawn freeze).
module tb_player_mover;

  logic       CLK = 1'b0;
  logic       reset;
  logic       go;
  logic       key_up, key_down, key_left, key_right;
  logic       hit;
  logic [7:0] x_dot;
  logic [6:0] y_dot;
  logic [7:0] score;
  logic       win_pulse;
  logic       dead;

  int errors = 0;
  int checks = 0;

  player_mover #(
    .RESPAWN_CYCLES(25'd5)
  ) dut (
    .CLK(CLK), .reset(reset), .go(go),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .hit(hit), .x_dot(x_dot), .y_dot(y_dot), .score(score),
    .win_pulse(win_pulse), .dead(dead)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic keys(input logic u, input logic d, input logic l, input logic r);
    key_up = u; key_down = d; key_left = l; key_right = r;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Press a key pattern for one cycle, check position, then release for one cycle
  task automatic press(input logic u, input logic d, input logic l, input logic r,
                       input string tag, input int ex, input int ey);
    keys(u, d, l, r);
    tick();
    check({tag, "_x"}, x_dot, ex);
    check({tag, "_y"}, y_dot, ey);
    keys(0, 0, 0, 0);
    tick();
  endtask

  initial begin
    reset = 1; go = 0; hit = 0;
    keys(0, 0, 0, 0);
    tick(); tick();
    reset = 0;
    check("rst_x", x_dot, 80);
    check("rst_y", y_dot, 110);
    check("rst_score", score, 0);
    check("rst_win", win_pulse, 0);
    check("rst_dead", dead, 0);

    // IDLE ignores keys and hit
    press(1, 0, 0, 0, "idle_up", 80, 110);
    hit = 1; tick(); hit = 0;
    check("idle_hit_dead", dead, 0);

    go = 1; tick(); go = 0;

    // Climb lanes 110 -> 10, then the crossing
    for (int i = 0; i < 5; i++) press(1, 0, 0, 0, "up", 80, 110 - 20 * (i + 1));
    keys(1, 0, 0, 0); tick();
    check("win_pulse_hi", win_pulse, 1);
    check("win_score", score, 1);
    check("win_y", y_dot, 110);
    check("win_x", x_dot, 80);
    keys(0, 0, 0, 0); tick();
    check("win_pulse_lo", win_pulse, 0);
    check("win_score_hold", score, 1);

    // Priority: up beats left on the same edge
    press(1, 0, 1, 0, "up_left", 80, 90);
    press(0, 1, 0, 0, "down", 80, 110);
    press(0, 1, 0, 0, "down_blocked", 80, 110);

    // Held key moves once only
    keys(1, 0, 0, 0); tick(); tick(); tick();
    check("held_y", y_dot, 90);
    keys(0, 0, 0, 0); tick();
    press(0, 1, 0, 0, "down2", 80, 110);

    // Right edge clamp: 80 -> 158 -> 159 -> 159
    for (int i = 0; i < 39; i++) press(0, 0, 0, 1, "right", 80 + 2 * (i + 1), 110);
    press(0, 0, 0, 1, "right_clamp", 159, 110);
    press(0, 0, 0, 1, "right_hold", 159, 110);
    // Left edge clamp: 159 -> 1 -> 0 -> 0
    for (int i = 0; i < 79; i++) press(0, 0, 1, 0, "left", 159 - 2 * (i + 1), 110);
    press(0, 0, 1, 0, "left_clamp", 0, 110);
    press(0, 0, 1, 0, "left_hold", 0, 110);

    // Hit with a simultaneous up press: freeze without moving
    hit = 1; keys(1, 0, 0, 0); tick();
    check("hit_dead", dead, 1);
    check("hit_nomove_y", y_dot, 110);
    check("hit_nomove_x", x_dot, 0);
    hit = 0; keys(0, 0, 0, 1); tick();
    check("dead_key_x", x_dot, 0);
    check("dead_1", dead, 1);
    keys(0, 0, 0, 0); tick(); tick(); tick();
    check("dead_4", dead, 1);
    check("dead_score", score, 1);
    tick();
    check("respawn_dead", dead, 0);
    check("respawn_x", x_dot, 80);
    check("respawn_y", y_dot, 110);
    check("respawn_score", score, 0);
    press(1, 0, 0, 0, "idle2_up", 80, 110);

    // Second round: score a crossing, then reset mid-DEAD
    go = 1; tick(); go = 0;
    press(1, 0, 0, 0, "r2_up", 80, 90);
    for (int i = 0; i < 4; i++) press(1, 0, 0, 0, "r2_up", 80, 70 - 20 * i);
    keys(1, 0, 0, 0); tick();
    check("r2_score", score, 1);
    keys(0, 0, 0, 0); tick();
    press(1, 0, 0, 0, "r2_up90", 80, 90);
    hit = 1; tick(); hit = 0;
    check("r2_dead", dead, 1);
    tick();
    reset = 1; tick(); reset = 0;
    check("mid_rst_x", x_dot, 80);
    check("mid_rst_y", y_dot, 110);
    check("mid_rst_score", score, 0);
    check("mid_rst_dead", dead, 0);
    check("mid_rst_win", win_pulse, 0);
    press(1, 0, 0, 0, "mid_rst_idle", 80, 110);

    // go held through DEAD re-enters PLAY right after IDLE
    go = 1; tick();
    hit = 1; tick(); hit = 0;
    check("go_dead", dead, 1);
    tick(); tick(); tick(); tick(); tick();
    check("go_respawn", dead, 0);
    tick();
    go = 0;
    press(1, 0, 0, 0, "go_held_up", 80, 90);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
